// File: rtl/operand_fetch_pkg.sv
// Shared constants, operand bundle type and bypass helper for the operand fetch stage.
package operand_fetch_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 2 ** AW;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] rd;
    logic          rd_we;
  } operand_bundle_t;

  // Register 0 is hardwired, so a writeback to it never forwards.
  function automatic logic wb_hit(input logic wb_we, input logic [AW-1:0] wb_num,
                                  input logic [AW-1:0] r);
    return wb_we && (wb_num == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bus bundle between decode, register file, writeback and execute for operand fetch.
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rs;
  logic [AW-1:0]   in_rt;
  logic [AW-1:0]   in_rd;
  logic            in_rd_we;
  logic [AW-1:0]   rf_r1_num;
  logic [AW-1:0]   rf_r2_num;
  logic [DW-1:0]   rf_r1_data;
  logic [DW-1:0]   rf_r2_data;
  logic            wb_we;
  logic [AW-1:0]   wb_num;
  logic [DW-1:0]   wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_a;
  logic [DW-1:0]   out_b;
  logic [AW-1:0]   out_rd;
  logic            out_rd_we;
  logic [NREG-1:0] busy_vec;

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_rd_we,
    input  rf_r1_data, rf_r2_data,
    input  wb_we, wb_num, wb_data,
    input  out_ready,
    output in_ready, rf_r1_num, rf_r2_num,
    output out_valid, out_a, out_b, out_rd, out_rd_we, busy_vec
  );

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_rd_we,
    output rf_r1_data, rf_r2_data,
    output wb_we, wb_num, wb_data,
    output out_ready,
    input  in_ready, rf_r1_num, rf_r2_num,
    input  out_valid, out_a, out_b, out_rd, out_rd_we, busy_vec
  );

endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with three combinational lookups.
module operand_fetch_reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en_i,
  input  logic [AW-1:0]   set_idx_i,
  input  logic            clr_en_i,
  input  logic [AW-1:0]   clr_idx_i,
  input  logic [AW-1:0]   rd_a_idx_i,
  input  logic [AW-1:0]   rd_b_idx_i,
  input  logic [AW-1:0]   rd_c_idx_i,
  output logic            busy_a_o,
  output logic            busy_b_o,
  output logic            busy_c_o,
  output logic [NREG-1:0] busy_vec_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a new claim survives a same-cycle retire.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_a_o   = busy_q[rd_a_idx_i];
  assign busy_b_o   = busy_q[rd_b_idx_i];
  assign busy_c_o   = busy_q[rd_c_idx_i];
  assign busy_vec_o = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register-file read, writeback bypass, hazard stall and a one-entry output register.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  operand_fetch_if.slave  bus
);

  logic            busy_rs, busy_rt, busy_rd;
  logic            hit_rs, hit_rt, hit_rd;
  logic            hazard;
  logic            in_ready;
  logic            accept;
  logic            set_en;
  logic [DW-1:0]   src_a, src_b;
  logic            out_valid_q, out_valid_d;
  operand_bundle_t bundle_q, bundle_d;

  assign bus.rf_r1_num = bus.in_rs;
  assign bus.rf_r2_num = bus.in_rt;

  assign hit_rs = wb_hit(bus.wb_we, bus.wb_num, bus.in_rs);
  assign hit_rt = wb_hit(bus.wb_we, bus.wb_num, bus.in_rt);
  assign hit_rd = wb_hit(bus.wb_we, bus.wb_num, bus.in_rd);

  // The register file only updates at the edge, so writeback data must be forwarded here.
  assign src_a = (bus.in_rs == REG_ZERO) ? '0 : (hit_rs ? bus.wb_data : bus.rf_r1_data);
  assign src_b = (bus.in_rt == REG_ZERO) ? '0 : (hit_rt ? bus.wb_data : bus.rf_r2_data);

  assign hazard = (busy_rs && !hit_rs)
               || (busy_rt && !hit_rt)
               || (bus.in_rd_we && (bus.in_rd != REG_ZERO) && busy_rd && !hit_rd);

  assign in_ready = !hazard && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign set_en   = accept && bus.in_rd_we && (bus.in_rd != REG_ZERO);

  operand_fetch_reg_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (set_en),
    .set_idx_i  (bus.in_rd),
    .clr_en_i   (bus.wb_we),
    .clr_idx_i  (bus.wb_num),
    .rd_a_idx_i (bus.in_rs),
    .rd_b_idx_i (bus.in_rt),
    .rd_c_idx_i (bus.in_rd),
    .busy_a_o   (busy_rs),
    .busy_b_o   (busy_rt),
    .busy_c_o   (busy_rd),
    .busy_vec_o (bus.busy_vec)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      bundle_d.a     = src_a;
      bundle_d.b     = src_b;
      bundle_d.rd    = bus.in_rd;
      bundle_d.rd_we = bus.in_rd_we;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = bundle_q.a;
  assign bus.out_b     = bundle_q.b;
  assign bus.out_rd    = bundle_q.rd;
  assign bus.out_rd_we = bundle_q.rd_we;

endmodule
